// File: rtl/vram_dump_if.sv
// vram_dump_if: start/status, VRAM read port and byte-stream signals of the VRAM dumper
interface vram_dump_if;
  logic i_start;
  logic o_running;
  logic o_done;
  logic [10:0] o_vram_addr;
  logic o_vram_ce;
  logic o_vram_w;
  logic [8:0] i_vram_dout;
  logic [7:0] o_tx_data;
  logic o_tx_valid;
  logic i_tx_ready;
  modport master (
    input i_start, i_vram_dout, i_tx_ready,
    output o_running, o_done, o_vram_addr, o_vram_ce, o_vram_w, o_tx_data, o_tx_valid
  );
  modport slave (
    output i_start, i_vram_dout, i_tx_ready,
    input o_running, o_done, o_vram_addr, o_vram_ce, o_vram_w, o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/vram_dump.sv
// vram_dump: walks VRAM first_addr..last_addr, streams low bytes with CR LF at row ends
module vram_dump #(
  parameter logic [10:0] first_addr = 11'h000,
  parameter logic [10:0] last_addr = 11'h7FF,
  parameter logic eol = 1'b1,
  parameter logic [7:0] nul_char = 8'h20
) (
  input logic i_clk,
  input logic i_rst,
  vram_dump_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, CR, LF} state_t;
  state_t state_q, state_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d, ce_q, ce_d, run_q, run_d, done_q, done_d;
  logic hs, last, row_end, adv;
  logic unused;
  assign unused = bus.i_vram_dout[8];
  assign hs = valid_q & bus.i_tx_ready;
  assign last = addr_q == last_addr;
  assign row_end = eol && (addr_q[5:0] == 6'h3F || last);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    valid_d = valid_q;
    ce_d = 1'b0;
    run_d = run_q;
    done_d = 1'b0;
    adv = 1'b0;
    case (state_q)
      IDLE: if (bus.i_start) begin
        state_d = FETCH;
        addr_d = first_addr;
        ce_d = 1'b1;
        run_d = 1'b1;
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        state_d = SEND;
        data_d = bus.i_vram_dout[7:0] == 8'h00 ? nul_char : bus.i_vram_dout[7:0];
        valid_d = 1'b1;
      end
      SEND: if (hs) begin
        state_d = row_end ? CR : state_q;
        data_d = row_end ? 8'h0D : data_q;
        adv = !row_end;
      end
      CR: if (hs) begin
        state_d = LF;
        data_d = 8'h0A;
      end
      LF: adv = hs;
      default: state_d = IDLE;
    endcase
    // one shared exit path: either finish at last_addr or step to the next cell
    if (adv) begin
      valid_d = 1'b0;
      if (last) begin
        state_d = IDLE;
        run_d = 1'b0;
        done_d = 1'b1;
      end else begin
        state_d = FETCH;
        addr_d = addr_q + 11'd1;
        ce_d = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ce_q <= 1'b0;
      run_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ce_q <= ce_d;
      run_q <= run_d;
      done_q <= done_d;
    end
  end
  assign bus.o_running = run_q;
  assign bus.o_done = done_q;
  assign bus.o_vram_addr = addr_q;
  assign bus.o_vram_ce = ce_q;
  assign bus.o_vram_w = 1'b0;
  assign bus.o_tx_data = data_q;
  assign bus.o_tx_valid = valid_q;
endmodule

// File: tb/tb_vram_dump.sv
// tb_vram_dump: directed checks of a short-range dumper and a full default-range dumper
module tb_vram_dump;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  int n;
  always #5 clk = ~clk;
  vram_dump_if ifa();
  vram_dump_if ifb();
  vram_dump #(.first_addr(11'h03E), .last_addr(11'h041)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa.master));
  vram_dump dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb.master));
  localparam logic [7:0] exp_bytes [8] = '{8'h41, 8'h42, 8'h0D, 8'h0A, 8'h20, 8'hFF, 8'h0D, 8'h0A};
  localparam logic [10:0] exp_addrs [4] = '{11'h03E, 11'h03F, 11'h040, 11'h041};
  function automatic logic [8:0] mem_a(input logic [10:0] a);
    case (a)
      11'h03E: return 9'h041;
      11'h03F: return 9'h042;
      11'h040: return 9'h000;
      11'h041: return 9'h1FF;
      default: return 9'h0AA;
    endcase
  endfunction
  function automatic logic [8:0] mem_b(input logic [10:0] a);
    return a[3:0] == 4'h0 ? 9'h100 : {1'b0, 4'h4, a[3:0]};
  endfunction
  always @(posedge clk) if (ifa.o_vram_ce) ifa.i_vram_dout <= mem_a(ifa.o_vram_addr);
  always @(posedge clk) if (ifb.o_vram_ce) ifb.i_vram_dout <= mem_b(ifb.o_vram_addr);
  logic [7:0] bytes_a [$];
  logic [10:0] addrs_a [$];
  int done_a = 0;
  always @(negedge clk) begin
    if (ifa.o_tx_valid && ifa.i_tx_ready) bytes_a.push_back(ifa.o_tx_data);
    if (ifa.o_vram_ce) addrs_a.push_back(ifa.o_vram_addr);
    if (ifa.o_done) done_a++;
  end
  int xfer_b = 0, cr_b = 0, lf_b = 0, ce_b = 0, bad_b = 0, w_b = 0, wrap_b = 0, done_b = 0;
  logic [10:0] cur_b = '0;
  always @(negedge clk) begin
    if (ifb.o_vram_w) w_b++;
    if (ifb.o_done) done_b++;
    if (ifb.o_vram_ce) begin
      if (ifb.o_vram_addr == 11'h000 && ce_b != 0) wrap_b++;
      ce_b++;
      cur_b = ifb.o_vram_addr;
    end
    if (ifb.o_tx_valid && ifb.i_tx_ready) begin
      xfer_b++;
      if (ifb.o_tx_data == 8'h0D) begin
        cr_b++;
        if (cur_b[5:0] != 6'h3F) bad_b++;
      end else if (ifb.o_tx_data == 8'h0A) lf_b++;
      else if (ifb.o_tx_data != (cur_b[3:0] == 4'h0 ? 8'h20 : {4'h4, cur_b[3:0]})) bad_b++;
    end
  end
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(input bit sel, input int limit, output int k);
    k = 0;
    while (!(sel ? ifb.o_done : ifa.o_done) && k < limit) begin
      tick(1);
      k++;
    end
  endtask
  task automatic clear_a();
    bytes_a.delete();
    addrs_a.delete();
    done_a = 0;
  endtask
  task automatic check_a(input string tag);
    chk({tag, "_nbytes"}, bytes_a.size(), 8);
    for (int i = 0; i < 8 && i < bytes_a.size(); i++) chk({tag, "_byte"}, bytes_a[i], exp_bytes[i]);
    chk({tag, "_naddrs"}, addrs_a.size(), 4);
    for (int i = 0; i < 4 && i < addrs_a.size(); i++) chk({tag, "_addr"}, addrs_a[i], exp_addrs[i]);
    chk({tag, "_ndone"}, done_a, 1);
  endtask
  task automatic check_a_zero(input string tag);
    chk({tag, "_running"}, ifa.o_running, 0);
    chk({tag, "_done"}, ifa.o_done, 0);
    chk({tag, "_addr"}, ifa.o_vram_addr, 0);
    chk({tag, "_ce"}, ifa.o_vram_ce, 0);
    chk({tag, "_w"}, ifa.o_vram_w, 0);
    chk({tag, "_data"}, ifa.o_tx_data, 0);
    chk({tag, "_valid"}, ifa.o_tx_valid, 0);
  endtask
  initial begin
    rst = 1'b1;
    ifa.i_start = 1'b1;
    ifa.i_tx_ready = 1'b1;
    ifb.i_start = 1'b0;
    ifb.i_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_ce", ifa.o_vram_ce, 0);
    end
    check_a_zero("rst");
    chk("rst_b_running", ifb.o_running, 0);
    clear_a();
    rst = 1'b0;
    tick(1);
    ifa.i_start = 1'b0;
    chk("start_running", ifa.o_running, 1);
    chk("start_ce", ifa.o_vram_ce, 1);
    chk("start_addr", ifa.o_vram_addr, 11'h03E);
    wait_done(1'b0, 60, n);
    chk("a_latency", n, 16);
    chk("a_done_pulse", ifa.o_done, 1);
    chk("a_done_running", ifa.o_running, 0);
    tick(1);
    chk("a_done_width", ifa.o_done, 0);
    check_a("range");
    clear_a();
    ifa.i_tx_ready = 1'b0;
    ifa.i_start = 1'b1;
    tick(1);
    ifa.i_start = 1'b0;
    tick(2);
    chk("bp_first_valid", ifa.o_tx_valid, 1);
    chk("bp_first_data", ifa.o_tx_data, 8'h41);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_valid", ifa.o_tx_valid, 1);
      chk("bp_data", ifa.o_tx_data, 8'h41);
      chk("bp_addr", ifa.o_vram_addr, 11'h03E);
      chk("bp_ce", ifa.o_vram_ce, 0);
    end
    ifa.i_tx_ready = 1'b1;
    tick(1);
    ifa.i_tx_ready = 1'b0;
    chk("bp_one_xfer", bytes_a.size(), 1);
    chk("bp_next_ce", ifa.o_vram_ce, 1);
    chk("bp_next_addr", ifa.o_vram_addr, 11'h03F);
    chk("bp_next_valid", ifa.o_tx_valid, 0);
    tick(3);
    chk("bp_still_one", bytes_a.size(), 1);
    ifa.i_start = 1'b1;
    tick(1);
    ifa.i_start = 1'b0;
    ifa.i_tx_ready = 1'b1;
    wait_done(1'b0, 60, n);
    chk("ign_done_pulse", ifa.o_done, 1);
    tick(1);
    check_a("ignore");
    tick(5);
    chk("ign_no_restart", ifa.o_running, 0);
    chk("ign_single_done", done_a, 1);
    clear_a();
    ifa.i_start = 1'b1;
    tick(1);
    ifa.i_start = 1'b0;
    n = 0;
    while (!(ifa.o_tx_valid && ifa.o_tx_data == 8'h0D) && n < 50) begin
      tick(1);
      n++;
    end
    chk("mid_cr_reached", ifa.o_tx_valid && ifa.o_tx_data == 8'h0D, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_a_zero("mid");
    tick(3);
    chk("mid_no_done", done_a, 0);
    chk("mid_idle", ifa.o_running, 0);
    clear_a();
    ifa.i_start = 1'b1;
    tick(1);
    ifa.i_start = 1'b0;
    wait_done(1'b0, 60, n);
    chk("redump_latency", n, 16);
    tick(1);
    check_a("redump");
    ifb.i_start = 1'b1;
    tick(1);
    ifb.i_start = 1'b0;
    chk("full_running", ifb.o_running, 1);
    chk("full_first_addr", ifb.o_vram_addr, 11'h000);
    wait_done(1'b1, 7000, n);
    chk("full_cycles", n, 6208);
    tick(1);
    chk("full_xfers", xfer_b, 2112);
    chk("full_cr", cr_b, 32);
    chk("full_lf", lf_b, 32);
    chk("full_reads", ce_b, 2048);
    chk("full_bad_bytes", bad_b, 0);
    chk("full_wrap", wrap_b, 0);
    chk("full_w", w_b, 0);
    chk("full_done", done_b, 1);
    chk("full_end_addr", ifb.o_vram_addr, 11'h7FF);
    chk("full_idle", ifb.o_running, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vram_dump.md
# vram_dump

Sequential VRAM reader for the serial terminal. On a start pulse it walks text memory from `first_addr` to `last_addr` and emits the low 8 bits of each 9-bit cell as a byte stream on a valid/ready interface. It inserts CR LF at every row end, and sits between the VRAM read port and the UART transmitter. It is the read-side counterpart of the screen-clear writer and shares its address map: 11-bit address, 5-bit row in bits [10:6], 6-bit column in bits [5:0].

## Interface
Parameters:
- `first_addr`, 11'h000: first VRAM address dumped.
- `last_addr`, 11'h7FF: last VRAM address dumped; must be >= `first_addr`.
- `eol`, 1'b1: 1 = insert CR (8'h0D) and LF (8'h0A) after row ends; 0 = never.
- `nul_char`, 8'h20: byte sent in place of a cell whose low 8 bits are 8'h00.

Ports:
- `i_clk`, in, 1: clock. All logic on the rising edge.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_start`, in, 1: start request, sampled only in IDLE.
- `o_running`, out, 1: busy, high from the cycle after start is accepted until the dump completes.
- `o_done`, out, 1: one-cycle pulse in the cycle after the last byte handshake.
- `o_vram_addr`, out, 11: read address.
- `o_vram_ce`, out, 1: read enable.
- `o_vram_w`, out, 1: write enable; constant 0.
- `i_vram_dout`, in, 9: read data, valid one cycle after the `o_vram_ce` cycle.
- `o_tx_data`, out, 8: byte to the transmitter.
- `o_tx_valid`, out, 1: byte valid.
- `i_tx_ready`, in, 1: transmitter accepts the byte. A transfer occurs when valid and ready are both high at a rising edge.

## Operation
- States: IDLE, FETCH, CAPTURE, SEND, CR, LF.
- IDLE: if `i_start` is high, load addr ← `first_addr` and go to FETCH.
- FETCH: `o_vram_ce` = 1 with the current addr for exactly one cycle, then go to CAPTURE.
- CAPTURE: register the byte. Byte = `nul_char` if `i_vram_dout[7:0]` == 0, else `i_vram_dout[7:0]`. Bit 8 is discarded. Go to SEND.
- SEND: `o_tx_valid` = 1 and `o_tx_data` = the registered byte. Hold here until the handshake.
- After the SEND handshake, choose the next state:
  - If `eol` = 1 and (addr[5:0] == 6'h3F or addr == `last_addr`): go to CR.
  - Else if addr == `last_addr`: go to IDLE and pulse done.
  - Else: addr ← addr + 1, go to FETCH.
- CR: valid = 1, data = 8'h0D; on handshake go to LF.
- LF: valid = 1, data = 8'h0A. On handshake: if addr == `last_addr`, go to IDLE and pulse done; else addr ← addr + 1, go to FETCH.
- If a row end coincides with `last_addr`, exactly one CR LF is sent.
- The address counter never wraps; it stops at `last_addr`. A dump with `last_addr` = 11'h7FF never produces 11'h000.
- `i_start` is ignored outside IDLE. There is no restart mid-dump.
- While valid is high, `o_tx_data` is stable and valid does not drop before the handshake.

## Timing
- Reset values: `o_running` = 0, `o_done` = 0, `o_vram_addr` = 0, `o_vram_ce` = 0, `o_vram_w` = 0, `o_tx_data` = 0, `o_tx_valid` = 0; state = IDLE. Reset mid-dump aborts immediately with no done pulse.
- `i_start` is high at edge 0. The FETCH cycle follows: `o_running` = 1 and `o_vram_ce` = 1. CAPTURE is the next cycle, then the first valid appears one cycle after CAPTURE, i.e. 3 cycles after the start edge.
- `o_vram_ce` and `o_vram_addr` change only on entry to FETCH. `o_vram_ce` is 0 in every other state.
- With `i_tx_ready` held at 1:
  - each cell costs 3 cycles;
  - each CR LF adds 2 cycles;
  - the default full range takes 2048×3 + 32×2 = 6208 cycles from the first FETCH to the last handshake.
- `o_done` pulses in the cycle after the final handshake. `o_running` falls in that same cycle.
- A new start is accepted at the first edge at which `o_running` = 0.

## Test plan
- Reset: hold `i_rst` = 1 for 3 cycles with `i_start` = 1 → all outputs 0 and no `o_vram_ce`. Release reset → the dump begins one cycle later.
- Range boundary: `first_addr` = 11'h03E, `last_addr` = 11'h041. VRAM preload: 03E = 9'h041, 03F = 9'h042, 040 = 9'h000, 041 = 9'h1FF. With ready = 1 → byte stream 41 42 0D 0A 20 FF 0D 0A, then one `o_done` pulse. Reads occur at addresses 03E, 03F, 040, 041, one `o_vram_ce` cycle each.
- Backpressure: hold ready = 0 for 10 cycles while in SEND → valid and data stay stable, addr is unchanged, `o_vram_ce` = 0. Raise ready → exactly one transfer, with no duplicate or dropped byte.
- Start ignored: pulse `i_start` mid-dump → the address sequence and byte stream are identical to an undisturbed run, with one `o_done`.
- Mid-dump reset: assert `i_rst` during CR → in the next cycle all outputs are 0 and there is no done pulse. A fresh start then re-dumps from `first_addr`.
- Full default range, ready = 1, `eol` = 1 → 2112 transfers (2048 cells plus 32 CR LF pairs), done 6208 cycles after the first FETCH, and `o_vram_w` never asserts.
